// File: rtl/uart_tx_framer.sv
// uart_tx_framer: 8N1/8N2 UART transmitter fed by a valid/ready byte handshake, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) between data and stop.
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 87,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk_10,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_tx_framer: illegal parameter value");
    end

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [2:0]  bit_q;
    logic        stop_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;
`ifdef UART_TX_PARITY_EN
    logic        par_q;
`endif

    logic bit_end;
    logic last_stop;
    logic accept;

    assign cnt_d     = cnt_q + 16'd1;
    assign bit_end   = (cnt_q == CNT_LAST);
    assign last_stop = (state_q == S_STOP) && bit_end && (stop_q == STOP_LAST);
    // Ready in the final stop cycle lets the next start bit follow with no idle gap.
    assign tx_ready  = (state_q == S_IDLE) || last_stop;
    assign accept    = tx_valid && tx_ready;

    assign uart_tx = tx_q;
    assign busy    = busy_q;

    always_ff @(posedge clk_10) begin
        if (rst) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
        end else if (accept) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end else if (state_q != S_IDLE) begin
            cnt_q <= bit_end ? '0 : cnt_d;
            if (bit_end) begin
                case (state_q)
                    S_START: begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end
                    S_DATA: begin
                        // Shift register keeps the next data bit at index 1.
                        bit_q   <= bit_q + 3'd1;
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
`endif
                    S_STOP: begin
                        if (stop_q == STOP_LAST) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: per-cycle line model built from the frame bit list.
module tb_uart_tx_framer;

    localparam int CPB = 87;
    localparam int SB  = 1;
    localparam int ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = (9 + SB + PAR) * CPB;

    logic       clk_10 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_tx;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_10 = ~clk_10;

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(ODD)) dut (
        .clk_10  (clk_10),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .uart_tx (uart_tx),
        .busy    (busy)
    );

`ifdef UART_TX_PARITY_EN
    logic tx_ready_o;
    logic uart_tx_o;
    logic busy_o;
    uart_tx_framer #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(1)) dut_odd (
        .clk_10  (clk_10),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready_o),
        .uart_tx (uart_tx_o),
        .busy    (busy_o)
    );
`endif

    // Expected line level for bit slot b of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int b, input int odd);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PAR == 1 && b == 9) return (^d) ^ (odd != 0);
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk_10);
        #1;
    endtask

    // Sends the bytes in q back-to-back with tx_valid held, checking every cycle.
    task automatic run_stream(input logic [7:0] q[$], input bit garble, input logic [7:0] idle_data,
                              output int busy_n);
        logic exp;
        n_chk++;
        if (tx_ready !== 1'b1) $display("FAIL ready_pre: got %b want 1", tx_ready);
        else n_pass++;
        tx_valid = 1'b1;
        tx_data  = q[0];
        tick();
        busy_n = 0;
        for (int i = 0; i < q.size(); i++) begin
            for (int k = 0; k < FL; k++) begin
                exp = frame_bit(q[i], k / CPB, ODD);
                n_chk++;
                if ({uart_tx, busy, tx_ready} !== {exp, 1'b1, (k == FL - 1)})
                    $display("FAIL frame%0d cyc%0d {line,busy,ready}: got %b%b%b want %b1%b",
                             i, k, uart_tx, busy, tx_ready, exp, (k == FL - 1));
                else n_pass++;
`ifdef UART_TX_PARITY_EN
                n_chk++;
                if (uart_tx_o !== frame_bit(q[i], k / CPB, 1))
                    $display("FAIL odd_line frame%0d cyc%0d: got %b want %b",
                             i, k, uart_tx_o, frame_bit(q[i], k / CPB, 1));
                else n_pass++;
`endif
                if (busy === 1'b1) busy_n++;
                if (i + 1 == q.size()) begin
                    tx_valid = 1'b0;
                    tx_data  = idle_data;
                end else if (k == FL - 1) begin
                    tx_data = q[i+1];
                end else if (garble) begin
                    tx_data = 8'($urandom);
                end
                tick();
            end
        end
        n_chk++;
        if ({uart_tx, busy, tx_ready} !== 3'b101)
            $display("FAIL idle_after {line,busy,ready}: got %b%b%b want 101", uart_tx, busy, tx_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk_10);
        #1 rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            n_chk++;
            if ({uart_tx, tx_ready, busy} !== 3'b110)
                $display("FAIL reset_idle cyc%0d {line,ready,busy}: got %b%b%b want 110",
                         i, uart_tx, tx_ready, busy);
            else n_pass++;
        end
    endtask

    task automatic test_single_a5();
        int n;
        logic [15:0] mids;
        logic [15:0] want;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        n    = 0;
        mids = '1;
        while (busy === 1'b1 && n < 5000) begin
            if (n % CPB == CPB / 2) mids[n / CPB] = uart_tx;
            n++;
            tick();
        end
`ifdef UART_TX_PARITY_EN
        want = 16'hF800 | 16'b101_0100_1010;
`else
        want = 16'hFC00 | 16'b11_0100_1010;
`endif
        n_chk++;
        if (mids !== want) $display("FAIL a5_midbits: got %b want %b", mids, want);
        else n_pass++;
        n_chk++;
        if (n !== FL) $display("FAIL a5_busy_len: got %0d want %0d", n, FL);
        else n_pass++;
        n_chk++;
        if ({uart_tx, tx_ready} !== 2'b11) $display("FAIL a5_idle: got %b%b want 11", uart_tx, tx_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int bn;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        run_stream(q, 1'b0, 8'($urandom), bn);
        n_chk++;
        if (bn !== (PAR == 1 ? 1914 : 1740)) $display("FAIL b2b_busy_span: got %0d want %0d", bn,
                                                     (PAR == 1 ? 1914 : 1740));
        else n_pass++;
    endtask

    task automatic test_random_stream();
        logic [7:0] q[$];
        int bn;
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        run_stream(q, 1'b1, 8'($urandom), bn);
        n_chk++;
        if (bn !== 4 * FL) $display("FAIL rand_busy_span: got %0d want %0d", bn, 4 * FL);
        else n_pass++;
    endtask

    task automatic test_random_gaps();
        logic [7:0] q[$];
        int bn;
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 5)) begin
                tx_data = 8'($urandom);
                tick();
                n_chk++;
                if ({uart_tx, tx_ready, busy} !== 3'b110)
                    $display("FAIL gap_idle: got %b%b%b want 110", uart_tx, tx_ready, busy);
                else n_pass++;
            end
            q.delete();
            q.push_back(8'($urandom));
            run_stream(q, 1'b0, 8'($urandom), bn);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] q[$];
        int bn;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            n_chk++;
            if (uart_tx !== frame_bit(8'h3C, k / CPB, ODD))
                $display("FAIL pre_reset cyc%0d: got %b want %b", k, uart_tx, frame_bit(8'h3C, k / CPB, ODD));
            else n_pass++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({uart_tx, tx_ready, busy} !== 3'b110)
            $display("FAIL mid_reset {line,ready,busy}: got %b%b%b want 110", uart_tx, tx_ready, busy);
        else n_pass++;
        q.push_back(8'h81);
        run_stream(q, 1'b0, 8'($urandom), bn);
    endtask

    task automatic test_data_change();
        logic [7:0] q[$];
        int bn;
        q.push_back(8'h12);
        run_stream(q, 1'b0, 8'hEE, bn);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int n;
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            if (n == 9 * CPB + CPB / 2) begin
                n_chk++;
                if (uart_tx !== 1'b1) $display("FAIL parity_even: got %b want 1", uart_tx);
                else n_pass++;
                n_chk++;
                if (uart_tx_o !== 1'b0) $display("FAIL parity_odd: got %b want 0", uart_tx_o);
                else n_pass++;
            end
            n++;
            tick();
        end
        n_chk++;
        if (n !== 957) $display("FAIL parity_frame_len: got %0d want 957", n);
        else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_change();
        test_random_stream();
        test_random_gaps();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- 8N1-style UART transmitter: the transmit end of the serial link whose receiver sits inside challenge_top.
- Accepts bytes over a valid/ready handshake and serialises them LSB-first on a single idle-high line.
- Bit timing matches the receive side: 87 clk_10 cycles per bit (870 time units at a 10-unit clock).
- Used as the loopback/stimulus source in benches and as the reply path for status bytes.

Parameters:
- CLKS_PER_BIT, 87, clk_10 cycles per serial bit; legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk_10  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on an accepted handshake.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- uart_tx  output  1  serial line, idle high, registered output.
- busy  output  1  high while a frame (start through last stop bit) is on the line.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: uart_tx=1, tx_ready=1, busy=0, state=IDLE, baud counter=0, bit index=0.
- Handshake:
  - A transfer occurs on a cycle with tx_valid && tx_ready.
  - tx_data is latched into the shift register on that cycle; later changes to tx_data have no effect on the frame.
- tx_ready:
  - High in IDLE.
  - High in the final cycle of the final stop bit (counter==CLKS_PER_BIT-1), so bytes can be sent back-to-back with no idle gap.
  - Low at all other times.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START on an accept in the last stop cycle.
- Latency: uart_tx goes low on the first clock edge after the accept cycle. The start bit occupies exactly CLKS_PER_BIT cycles.
- Each bit (start, data, parity, stop):
  - Held for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- DATA: 8 bits, tx_data[0] first; the bit index advances 0..7 at each wrap.
- STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles without parity; 87 more with parity.
- busy:
  - Asserts on the same edge as the start bit.
  - Stays high through the last stop cycle.
  - Deasserts on the following edge, unless a back-to-back accept occurred, in which case it stays high continuously.
- tx_valid held high with no gap: successive frames are contiguous; no extra idle cycles are inserted.
- Reset mid-frame: on the reset edge, uart_tx returns to 1 and state goes to IDLE. The partial frame is abandoned and not resumed.
- tx_valid while not ready: ignored. The producer must hold data until it sees ready; no buffering beyond the shift register.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state between DATA and STOP drives the parity bit for CLKS_PER_BIT cycles.
  - Bit value = ^tx_data when PARITY_ODD=0 (even), ~^tx_data when PARITY_ODD=1 (odd).
- When undefined: no PARITY state, no parity logic, frame is 8N1 (or 8N2).

Test Plan:
- Reset and idle:
  - Hold rst for 3 cycles, then release with tx_valid=0.
  - Required: uart_tx=1, tx_ready=1, busy=0 for 1000 cycles.
- Single 0xA5, default parameters:
  - Line goes low one cycle after the accept.
  - Sampled at mid-bit (cycle 43 of each 87), the line reads 0,1,0,1,0,0,1,0,1,1.
  - busy is high for exactly 870 cycles.
- Back-to-back 0x00 then 0xFF, tx_valid held high:
  - The second accept occurs in cycle 869 of frame one.
  - Start bit of frame two immediately follows the stop bit, with no idle cycle.
  - Total busy span is 1740 cycles.
- Reset mid-frame:
  - Assert rst at cycle 400 of a 0x3C frame.
  - uart_tx=1 and tx_ready=1 on the next edge.
  - A new 0x81 then transmits correctly.
- tx_data changes after acceptance:
  - Accept 0x12, then change tx_data to 0xEE on the following cycle.
  - The line still carries 0x12.
- Parity, with UART_TX_PARITY_EN and PARITY_ODD=0:
  - Send 0x07: parity bit = 1, frame length 957 cycles.
  - With PARITY_ODD=1 the parity bit = 0.
